// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard front end for snake_device.
// Conditions the asynchronous PS/2 lines, deserialises 11-bit frames, tracks
// E0/F0 prefixes and turns arrow / WASD make codes into a one-hot direction.
module ps2_direction_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10647,
    parameter logic [3:0]  INIT_DIR       = 4'b0001
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_PS2Clk,
    input  logic       i_PS2Data,
    output logic [3:0] o_Direction,
    output logic       o_DirValid,
    output logic [7:0] o_Scancode,
    output logic       o_ByteValid,
    output logic       o_FrameErr
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic          r_data_filt;
    logic          r_clk_filt_d;
    logic [FW-1:0] r_clk_cnt;
    logic [FW-1:0] r_data_cnt;
    rx_state_t     r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_ext;
    logic          r_brk;
    logic          w_fall;
    logic [3:0]    w_dir;

    // Two-flop synchronisers; preset to 1 so the idle bus looks idle out of reset.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value, so the chain really is two stages.
            r_clk_sync  <= {r_clk_sync[0], i_PS2Clk};
            r_data_sync <= {r_data_sync[0], i_PS2Data};
        end
    end

    // Clock-line glitch filter: output flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_clk_filt <= 1'b1;
            r_clk_cnt  <= '0;
        end else if (r_clk_sync[1] != r_clk_filt) begin
            if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_clk_cnt  <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end else begin
            r_clk_cnt <= '0;
        end
    end

    // Data-line glitch filter, identical to the clock filter.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_data_filt <= 1'b1;
            r_data_cnt  <= '0;
        end else if (r_data_sync[1] != r_data_filt) begin
            if (r_data_cnt == FW'(FILTER_LEN - 1)) begin
                r_data_filt <= r_data_sync[1];
                r_data_cnt  <= '0;
            end else begin
                r_data_cnt <= r_data_cnt + 1'b1;
            end
        end else begin
            r_data_cnt <= '0;
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) r_clk_filt_d <= 1'b1;
        else        r_clk_filt_d <= r_clk_filt;
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // Receive FSM: advances on filtered falling edges, aborts on inter-edge timeout.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            o_Scancode  <= 8'h00;
            o_ByteValid <= 1'b0;
            o_FrameErr  <= 1'b0;
        end else begin
            o_ByteValid <= 1'b0;
            o_FrameErr  <= 1'b0;
            if (w_fall) begin
                // An edge always wins over a timeout landing on the same cycle.
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!r_data_filt) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            o_FrameErr <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_data_filt, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                        else                   r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: begin
                        r_parity <= r_data_filt;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        if (r_data_filt && (^{r_shift, r_parity})) begin
                            o_Scancode  <= r_shift;
                            o_ByteValid <= 1'b1;
                        end else begin
                            o_FrameErr <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state    <= S_IDLE;
                r_to_cnt   <= '0;
                o_FrameErr <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Make-code lookup for the current byte under the current E0 prefix.
    always_comb begin
        // NOTE: default first so every path assigns w_dir and no latch is inferred.
        w_dir = 4'b0000;
        if (r_ext) begin
            case (o_Scancode)
                8'h75:   w_dir = 4'b1000;
                8'h72:   w_dir = 4'b0100;
                8'h6B:   w_dir = 4'b0010;
                8'h74:   w_dir = 4'b0001;
                default: w_dir = 4'b0000;
            endcase
        end else begin
            case (o_Scancode)
                8'h1D:   w_dir = 4'b1000;
                8'h1B:   w_dir = 4'b0100;
                8'h1C:   w_dir = 4'b0010;
                8'h23:   w_dir = 4'b0001;
                default: w_dir = 4'b0000;
            endcase
        end
    end

    // Prefix tracking and direction update; frame errors flush stale prefixes.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            o_Direction <= INIT_DIR;
            o_DirValid  <= 1'b0;
        end else begin
            o_DirValid <= 1'b0;
            if (o_FrameErr) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (o_ByteValid) begin
                if (o_Scancode == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (o_Scancode == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (!r_brk && (w_dir != 4'b0000)) begin
                        o_Direction <= w_dir;
                        o_DirValid  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: bit-bangs PS/2 frames and checks
// decoded direction, byte/direction/error pulse counts and timeout latency.
module tb_ps2_direction_decoder;

    localparam int HALF = 40;
    localparam int TO   = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [3:0] o_Direction;
    logic       o_DirValid;
    logic [7:0] o_Scancode;
    logic       o_ByteValid;
    logic       o_FrameErr;

    int checks = 0;
    int errors = 0;
    int n_bv = 0;
    int n_dv = 0;
    int n_err = 0;
    int cyc = 0;
    int err_cyc = 0;
    int fall_cyc = 0;

    ps2_direction_decoder #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TO),
        .INIT_DIR      (4'b0001)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_PS2Clk   (ps2c),
        .i_PS2Data  (ps2d),
        .o_Direction(o_Direction),
        .o_DirValid (o_DirValid),
        .o_Scancode (o_Scancode),
        .o_ByteValid(o_ByteValid),
        .o_FrameErr (o_FrameErr)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (o_ByteValid) n_bv <= n_bv + 1;
        if (o_DirValid)  n_dv <= n_dv + 1;
        if (o_FrameErr) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, then a low phase; optional 3-cycle clock glitch.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2d = b;
        if (glitch) begin
            idle(15);
            ps2c = 1'b0;
            idle(3);
            ps2c = 1'b1;
            idle(HALF - 18);
        end else begin
            idle(HALF);
        end
        ps2c     = 1'b0;
        fall_cyc = cyc;
        idle(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit glitch);
        logic par;
        par = (~^b) ^ flip_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit(par, glitch);
        ps2_bit(1'b1, glitch);
        ps2d = 1'b1;
        idle(HALF);
    endtask

    initial begin
        int bv0;
        int err0;
        int delta;
        int budget;

        // Frame driven while held in reset must be ignored.
        idle(5);
        send_byte(8'h75, 1'b0, 1'b0);
        check("rst_dir", o_Direction, 4'b0001);
        check("rst_scan", o_Scancode, 8'h00);
        check("rst_pulses", n_bv + n_dv + n_err, 0);
        rst_n = 1'b1;
        idle(1000);
        check("idle_dir", o_Direction, 4'b0001);
        check("idle_scan", o_Scancode, 8'h00);
        check("idle_pulses", n_bv + n_dv + n_err, 0);

        // Reset mid-frame discards the partial frame without a later timeout.
        for (int i = 0; i < 4; i++) ps2_bit(1'b0, 1'b0);
        ps2d  = 1'b1;
        rst_n = 1'b0;
        idle(5);
        rst_n = 1'b1;
        idle(TO + 100);
        check("midrst_err", n_err, 0);

        // Extended up arrow.
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        check("up_bv", n_bv, 2);
        check("up_dv", n_dv, 1);
        check("up_dir", o_Direction, 4'b1000);
        check("up_scan", o_Scancode, 8'h75);

        // WASD left, release of left, then down.
        send_byte(8'h1C, 1'b0, 1'b0);
        check("left_dir", o_Direction, 4'b0010);
        check("left_dv", n_dv, 2);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        check("brk_dir", o_Direction, 4'b0010);
        check("brk_dv", n_dv, 2);
        send_byte(8'h1B, 1'b0, 1'b0);
        check("down_dir", o_Direction, 4'b0100);
        check("down_dv", n_dv, 3);

        // Parity error, then the same byte sent correctly.
        bv0 = n_bv;
        send_byte(8'h23, 1'b1, 1'b0);
        check("par_err", n_err, 1);
        check("par_bv", n_bv, bv0);
        check("par_dir", o_Direction, 4'b0100);
        send_byte(8'h23, 1'b0, 1'b0);
        check("right_dir", o_Direction, 4'b0001);
        check("right_scan", o_Scancode, 8'h23);

        // Bad start bit after E0 clears the prefix, so 75 no longer maps to up.
        send_byte(8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        idle(HALF);
        check("start_err", n_err, 2);
        send_byte(8'h75, 1'b0, 1'b0);
        check("stale_dir", o_Direction, 4'b0001);
        check("stale_dv", n_dv, 4);

        // Timeout: start plus four data bits then a stalled clock.
        err0 = n_err;
        for (int i = 0; i < 5; i++) ps2_bit(1'b0, 1'b0);
        ps2d   = 1'b1;
        budget = TO + 200;
        while (n_err == err0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("to_fired", n_err, err0 + 1);
        delta = err_cyc - fall_cyc;
        check("to_delay", (delta >= TO + 5) && (delta <= TO + 20), 1'b1);
        idle(20);
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h74, 1'b0, 1'b0);
        check("to_recover_dir", o_Direction, 4'b0001);
        check("to_recover_dv", n_dv, 5);

        // Clock glitches inside a frame must not shift extra bits.
        err0 = n_err;
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h72, 1'b0, 1'b1);
        check("glitch_dir", o_Direction, 4'b0100);
        check("glitch_scan", o_Scancode, 8'h72);
        check("glitch_err", n_err, err0);
        check("glitch_dv", n_dv, 6);

        // Typematic repeat of the same key still pulses o_DirValid.
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h72, 1'b0, 1'b0);
        check("repeat_dv", n_dv, 7);
        check("repeat_dir", o_Direction, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
